// File: rtl/axi4_master.sv
// AXI4 burst master: takes one command at a time and runs a single read or write burst.
// Write data streams in through a one-entry W register. Read data streams out with no backpressure.
module axi4_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic [1:0]            rd_resp,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [1:0]            AWBURST,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [1:0]            ARBURST,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  RLAST,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY
);

    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_ERR
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_cmd_ready;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [7:0]            r_beat;
    logic                  r_w_done;
    logic                  r_wvalid, r_wlast;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [1:0]            r_rmax;
    logic                  r_rerr;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid, r_rd_last;
    logic [1:0]            r_rd_resp;
    logic                  r_done;
    logic [1:0]            r_done_resp;

    logic       w_cmd_ok;
    logic       w_cmd_hs, w_wr_load, w_w_hs, w_b_hs, w_r_hs;
    logic       w_r_at_len, w_r_lerr;
    logic [1:0] w_rmax_nxt;

    // Illegal bursts are rejected before any address phase is issued.
    always_comb begin
        w_cmd_ok = 1'b1;
        if (cmd_burst == 2'b11)
            w_cmd_ok = 1'b0;
        if (cmd_burst == 2'b10 && !(cmd_len == 8'd1 || cmd_len == 8'd3 ||
                                    cmd_len == 8'd7 || cmd_len == 8'd15))
            w_cmd_ok = 1'b0;
        if (cmd_size > 3'(MAX_SIZE))
            w_cmd_ok = 1'b0;
        if (cmd_burst == 2'b00 && cmd_len > 8'd15)
            w_cmd_ok = 1'b0;
    end

    assign w_cmd_hs   = cmd_valid && r_cmd_ready;
    assign w_wr_load  = wr_valid && wr_ready;
    assign w_w_hs     = r_wvalid && WREADY;
    assign w_b_hs     = BVALID && BREADY;
    assign w_r_hs     = RVALID && RREADY;
    assign w_r_at_len = (r_beat == r_len);
    assign w_r_lerr   = (RLAST != w_r_at_len);
    assign w_rmax_nxt = (RRESP > r_rmax) ? RRESP : r_rmax;

    always_ff @(posedge ACLK) begin
        if (ARESET)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        AWVALID     = 1'b0;
        ARVALID     = 1'b0;
        BREADY      = 1'b0;
        RREADY      = 1'b0;
        wr_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_hs)
                    w_state_nxt = !w_cmd_ok ? S_ERR : (cmd_write ? S_AW : S_AR);
            end
            S_AW: begin
                AWVALID = 1'b1;
                if (AWREADY)
                    w_state_nxt = S_W;
            end
            S_W: begin
                // Refill the W register when it is empty or draining this cycle.
                wr_ready = !r_w_done && (!r_wvalid || WREADY);
                if (w_w_hs && r_wlast)
                    w_state_nxt = S_B;
            end
            S_B: begin
                BREADY = 1'b1;
                if (BVALID)
                    w_state_nxt = S_IDLE;
            end
            S_AR: begin
                ARVALID = 1'b1;
                if (ARREADY)
                    w_state_nxt = S_R;
            end
            S_R: begin
                RREADY = 1'b1;
                if (RVALID && w_r_at_len)
                    w_state_nxt = S_IDLE;
            end
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_beat      <= '0;
            r_w_done    <= 1'b0;
            r_wvalid    <= 1'b0;
            r_wlast     <= 1'b0;
            r_wdata     <= '0;
            r_rmax      <= '0;
            r_rerr      <= 1'b0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_resp   <= '0;
            r_done      <= 1'b0;
            r_done_resp <= '0;
        end else begin
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_done      <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;

            if (w_cmd_hs) begin
                r_addr   <= cmd_addr;
                r_len    <= cmd_len;
                r_size   <= cmd_size;
                r_burst  <= cmd_burst;
                r_beat   <= '0;
                r_w_done <= 1'b0;
                r_rmax   <= '0;
                r_rerr   <= 1'b0;
            end

            if (w_wr_load) begin
                r_wdata  <= wr_data;
                r_wvalid <= 1'b1;
                r_wlast  <= (r_beat == r_len);
                if (r_beat == r_len)
                    r_w_done <= 1'b1;
                else
                    r_beat <= r_beat + 8'd1;
            end else if (w_w_hs) begin
                r_wvalid <= 1'b0;
                r_wlast  <= 1'b0;
            end

            if (w_b_hs) begin
                r_done      <= 1'b1;
                r_done_resp <= BRESP;
            end

            if (r_state == S_ERR) begin
                r_done      <= 1'b1;
                r_done_resp <= 2'b10;
            end

            if (w_r_hs) begin
                r_rd_data  <= RDATA;
                r_rd_resp  <= RRESP;
                r_rd_last  <= RLAST;
                r_rd_valid <= 1'b1;
                r_rmax     <= w_rmax_nxt;
                r_rerr     <= r_rerr || w_r_lerr;
                // The beat count is what ends the burst. A disagreeing RLAST only marks it as failed.
                if (w_r_at_len) begin
                    r_done      <= 1'b1;
                    r_done_resp <= (r_rerr || w_r_lerr) ? 2'b10 : w_rmax_nxt;
                end else begin
                    r_beat <= r_beat + 8'd1;
                end
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign AWADDR    = r_addr;
    assign AWLEN     = r_len;
    assign AWSIZE    = r_size;
    assign AWBURST   = r_burst;
    assign ARADDR    = r_addr;
    assign ARLEN     = r_len;
    assign ARSIZE    = r_size;
    assign ARBURST   = r_burst;
    assign WDATA     = r_wdata;
    assign WVALID    = r_wvalid;
    assign WLAST     = r_wlast;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign rd_last   = r_rd_last;
    assign rd_resp   = r_rd_resp;
    assign done      = r_done;
    assign done_resp = r_done_resp;

endmodule

// File: tb/tb_axi4_master.sv
// Scoreboard bench for axi4_master. A subordinate model sits behind the AXI ports and a monitor
// pops expected transfers whenever the DUT presents a handshake, rd_valid or done.
module tb_axi4_master;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ax_t;
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } wb_t;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rb_t;

    logic        ACLK, ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [31:0] wr_data, rd_data;
    logic        wr_valid, wr_ready, rd_valid, rd_last, done;
    logic [1:0]  rd_resp, done_resp;
    logic [15:0] AWADDR, ARADDR;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;

    axi4_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_resp(rd_resp),
        .done(done), .done_resp(done_resp),
        .AWADDR(AWADDR), .AWBURST(AWBURST), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARBURST(ARBURST), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_vec = 0;
    int n_err = 0;

    ax_t         exp_aw[$];
    ax_t         exp_ar[$];
    wb_t         exp_w[$];
    rb_t         exp_rd[$];
    logic [1:0]  exp_done[$];
    logic [31:0] src_q[$];

    // Subordinate configuration, written by the stimulus process.
    int          aw_stall = 0;
    bit          w_toggle = 0;
    bit          junk     = 0;
    logic [1:0]  b_resp   = 2'b00;
    logic [31:0] rr_base  = 32'h0;
    int          rr_beats = 0;
    int          rr_last  = 0;
    logic [1:0]  rr_resp [16];
    int          aw_cyc = 0;
    int          ar_cyc = 0;
    int          w_hs_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexp(input string name, input logic [63:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s_unexpected: got %0h, expected no transfer", name, act);
    endtask

    // Subordinate and write-data source. Handshakes are sampled at negedge and acted on after posedge.
    initial begin : slave
        bit s_w_hs, s_wlast, s_b_hs, s_ar_hs, s_r_hs, s_src_hs;
        int aw_cnt, r_idx;
        aw_cnt = 0; r_idx = 0;
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b0; BRESP = 2'b00;
        ARREADY = 1'b1; RVALID = 1'b0; RDATA = '0; RLAST = 1'b0; RRESP = 2'b00;
        wr_valid = 1'b0; wr_data = '0;
        forever begin
            @(negedge ACLK);
            s_w_hs   = WVALID && WREADY;
            s_wlast  = WLAST;
            s_b_hs   = BVALID && BREADY;
            s_ar_hs  = ARVALID && ARREADY;
            s_r_hs   = RVALID && RREADY;
            s_src_hs = wr_valid && wr_ready;
            @(posedge ACLK);
            #2;
            if (ARESET) begin
                BVALID = 1'b0; RVALID = 1'b0; RLAST = 1'b0; WREADY = 1'b1;
                src_q.delete(); aw_cnt = 0; r_idx = 0;
                wr_valid = 1'b0;
            end else begin
                if (AWVALID && aw_cnt < aw_stall) begin
                    AWREADY = 1'b0;
                    aw_cnt++;
                end else begin
                    AWREADY = 1'b1;
                    if (!AWVALID) aw_cnt = 0;
                end
                WREADY = w_toggle ? !WREADY : 1'b1;
                if (s_b_hs) BVALID = 1'b0;
                if (s_w_hs && s_wlast) begin
                    BVALID = 1'b1;
                    BRESP  = b_resp;
                end
                if (s_ar_hs) begin
                    r_idx  = 0;
                    RVALID = 1'b1;
                end else if (s_r_hs) begin
                    r_idx++;
                    if (r_idx >= rr_beats) RVALID = 1'b0;
                end
                RDATA = rr_base + 32'(r_idx);
                RRESP = (r_idx < 16) ? rr_resp[r_idx] : 2'b00;
                RLAST = (r_idx == rr_last);
                if (s_src_hs && src_q.size() != 0) void'(src_q.pop_front());
                wr_valid = (src_q.size() != 0) || junk;
                wr_data  = (src_q.size() != 0) ? src_q[0] : 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: compare every DUT-presented transfer against the scoreboard.
    initial begin : monitor
        bit          pend_aw, pend_w;
        logic [15:0] h_awaddr;
        logic [7:0]  h_awlen;
        logic [31:0] h_wdata;
        logic        h_wlast;
        ax_t ea;
        wb_t ew;
        rb_t er;
        logic [1:0] ed;
        pend_aw = 0; pend_w = 0;
        forever begin
            @(negedge ACLK);
            aw_cyc += int'(AWVALID);
            ar_cyc += int'(ARVALID);
            if (!ARESET) begin
                if (pend_aw) chk("aw_stable", {AWVALID, AWADDR, AWLEN}, {1'b1, h_awaddr, h_awlen});
                if (pend_w)  chk("w_stable", {WVALID, WDATA, WLAST}, {1'b1, h_wdata, h_wlast});
                pend_aw = AWVALID && !AWREADY; h_awaddr = AWADDR; h_awlen = AWLEN;
                pend_w  = WVALID && !WREADY;   h_wdata  = WDATA;  h_wlast = WLAST;
                if (AWVALID && AWREADY) begin
                    if (exp_aw.size() == 0) unexp("aw", {AWADDR, AWLEN});
                    else begin ea = exp_aw.pop_front(); chk("aw_cmd", {AWADDR, AWLEN, AWSIZE, AWBURST}, ea); end
                end
                if (ARVALID && ARREADY) begin
                    if (exp_ar.size() == 0) unexp("ar", {ARADDR, ARLEN});
                    else begin ea = exp_ar.pop_front(); chk("ar_cmd", {ARADDR, ARLEN, ARSIZE, ARBURST}, ea); end
                end
                if (WVALID && WREADY) begin
                    w_hs_cnt++;
                    if (exp_w.size() == 0) unexp("w", {WDATA, WLAST});
                    else begin ew = exp_w.pop_front(); chk("w_beat", {WDATA, WLAST}, ew); end
                end
                if (rd_valid) begin
                    if (exp_rd.size() == 0) unexp("rd", {rd_data, rd_resp, rd_last});
                    else begin er = exp_rd.pop_front(); chk("rd_beat", {rd_data, rd_resp, rd_last}, er); end
                end
                if (done) begin
                    if (exp_done.size() == 0) unexp("done", done_resp);
                    else begin ed = exp_done.pop_front(); chk("done_resp", done_resp, ed); end
                end
            end else begin
                pend_aw = 0;
                pend_w  = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic wr, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        bit got;
        got = 0;
        @(posedge ACLK); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_len = len; cmd_size = size; cmd_burst = burst;
        for (int i = 0; i < 100; i++) begin
            @(negedge ACLK);
            if (cmd_ready) begin got = 1; break; end
        end
        chk("cmd_accept", 64'(got), 64'd1);
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string name);
        int left;
        for (int i = 0; i < bound; i++) begin
            @(negedge ACLK); #1;
            left = exp_aw.size() + exp_ar.size() + exp_w.size() + exp_rd.size() + exp_done.size();
            if (left == 0) break;
        end
        left = exp_aw.size() + exp_ar.size() + exp_w.size() + exp_rd.size() + exp_done.size();
        chk(name, 64'(left), 64'd0);
    endtask

    task automatic plan_write(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                              input logic [31:0] base);
        exp_aw.push_back('{addr, len, 3'd2, burst});
        for (int i = 0; i <= int'(len); i++) begin
            src_q.push_back(base + 32'(i));
            exp_w.push_back('{base + 32'(i), (i == int'(len))});
        end
    endtask

    task automatic plan_read(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [31:0] base, input int last_idx);
        exp_ar.push_back('{addr, len, 3'd2, burst});
        rr_base = base; rr_beats = int'(len) + 1; rr_last = last_idx;
        for (int i = 0; i <= int'(len); i++)
            exp_rd.push_back('{base + 32'(i), rr_resp[i], (i == last_idx)});
    endtask

    initial begin : stim
        ARESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_len = '0; cmd_size = '0; cmd_burst = '0;
        for (int i = 0; i < 16; i++) rr_resp[i] = 2'b00;

        // Reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_valids", {AWVALID, WVALID, WLAST, ARVALID, BREADY, RREADY, rd_valid, rd_last, done}, 0);
        chk("rst_data", {AWADDR, AWLEN, WDATA, rd_data, rd_resp, done_resp}, 0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("rel_cmd_ready_0", cmd_ready, 0);
        @(negedge ACLK);
        chk("rel_cmd_ready_1", cmd_ready, 1);

        // INCR write, subordinate always ready
        plan_write(16'h0040, 8'd3, 2'b01, 32'h1111_0000);
        exp_done.push_back(2'b00);
        aw_cyc = 0;
        issue(1'b1, 16'h0040, 8'd3, 3'd2, 2'b01);
        wait_idle(60, "wr_incr_done");
        chk("wr_incr_awvalid_cycles", 64'(aw_cyc), 64'd1);

        // WRAP read with a SLVERR on beat 2. Junk write data is offered and must be ignored.
        rr_resp[2] = 2'b10;
        plan_read(16'h0018, 8'd3, 2'b10, 32'hA000_0000, 3);
        exp_done.push_back(2'b10);
        junk = 1;
        issue(1'b0, 16'h0018, 8'd3, 3'd2, 2'b10);
        wait_idle(60, "rd_wrap_done");
        rr_resp[2] = 2'b00;

        // Illegal commands: no bus traffic, quick error completion
        aw_cyc = 0; ar_cyc = 0;
        exp_done.push_back(2'b10);
        issue(1'b1, 16'h0000, 8'd5, 3'd2, 2'b10);
        wait_idle(2, "ill_wrap_len5");
        exp_done.push_back(2'b10);
        issue(1'b0, 16'h0010, 8'd0, 3'd2, 2'b11);
        wait_idle(2, "ill_burst3");
        exp_done.push_back(2'b10);
        issue(1'b1, 16'h0020, 8'd0, 3'd3, 2'b01);
        wait_idle(2, "ill_size3");
        exp_done.push_back(2'b10);
        issue(1'b0, 16'h0030, 8'd16, 3'd2, 2'b00);
        wait_idle(2, "ill_fixed_len16");
        exp_done.push_back(2'b10);
        issue(1'b0, 16'h0030, 8'd2, 3'd2, 2'b10);
        wait_idle(2, "ill_wrap_len2");
        chk("ill_no_axvalid", {32'(aw_cyc), 32'(ar_cyc)}, 64'd0);
        junk = 0;
        repeat (2) @(posedge ACLK);

        // AWREADY held low for 5 cycles and WREADY toggling every cycle
        aw_stall = 5; w_toggle = 1; b_resp = 2'b01;
        plan_write(16'h0200, 8'd3, 2'b01, 32'h2222_0000);
        exp_done.push_back(2'b01);
        aw_cyc = 0;
        issue(1'b1, 16'h0200, 8'd3, 3'd2, 2'b01);
        wait_idle(80, "wr_stall_done");
        chk("wr_stall_awvalid_cycles", 64'(aw_cyc), 64'd6);
        aw_stall = 0; w_toggle = 0; b_resp = 2'b00;

        // RLAST arrives early, on beat 3 of an 8-beat read
        plan_read(16'h0300, 8'd7, 2'b01, 32'hB000_0000, 3);
        exp_done.push_back(2'b10);
        issue(1'b0, 16'h0300, 8'd7, 3'd2, 2'b01);
        wait_idle(60, "rd_early_rlast_done");

        // Reset while W beat 2 of an 8-beat write is on the bus
        plan_write(16'h0400, 8'd7, 2'b01, 32'h3333_0000);
        w_hs_cnt = 0;
        issue(1'b1, 16'h0400, 8'd7, 3'd2, 2'b01);
        for (int i = 0; i < 60; i++) begin
            @(negedge ACLK); #1;
            if (w_hs_cnt >= 2) break;
        end
        chk("rst_mid_reached_beat2", 64'(w_hs_cnt), 64'd2);
        @(posedge ACLK); #1;
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        exp_aw.delete(); exp_w.delete(); exp_done.delete();
        @(negedge ACLK);
        chk("rst_mid_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, done, cmd_ready}, 0);
        @(negedge ACLK);
        chk("rst_mid_cmd_ready", {cmd_ready, done}, 2'b10);

        // FIXED read at the maximum legal length. EXOKAY on the final beat sets done_resp.
        rr_resp[15] = 2'b01;
        plan_read(16'h0500, 8'd15, 2'b00, 32'hC000_0000, 15);
        exp_done.push_back(2'b01);
        issue(1'b0, 16'h0500, 8'd15, 3'd2, 2'b00);
        wait_idle(80, "rd_fixed15_done");

        repeat (3) @(posedge ACLK);
        #1;
        chk("queues_drained", 64'(exp_aw.size() + exp_ar.size() + exp_w.size() + exp_rd.size() + exp_done.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_master.md
AXI4_MASTER -- requirements
Module: axi4_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI data bus width in bits (multiple of 8, 8..1024).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, AXI address width in bits.
REQ-003 ACLK  in  1  sole clock; all logic on rising edge.
REQ-004 ARESET  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-006 cmd_write  in  1  1=write burst, 0=read burst.
REQ-007 cmd_addr/cmd_len/cmd_size/cmd_burst  in  ADDR_WIDTH/8/3/2  burst start address, beats-1, log2 bytes per beat, burst type.
REQ-008 wr_data/wr_valid/wr_ready  in/in/out  DATA_WIDTH/1/1  write-data source stream.
REQ-009 rd_data/rd_valid/rd_last/rd_resp  out  DATA_WIDTH/1/1/2  read-data sink stream, no backpressure.
REQ-010 done/done_resp  out  1/2  one-cycle completion pulse, final response.
REQ-011 Full AXI4 manager ports AW*, W*, B*, AR*, R* SHALL match the subordinate memory block by name and width (AxADDR, AxBURST, AxLEN, AxSIZE, AxVALID/AxREADY, WDATA, WLAST, WVALID/WREADY, BRESP, BVALID/BREADY, RDATA, RLAST, RRESP, RVALID/RREADY).

Function
REQ-012 SHALL run FSM states IDLE, AW, W, B, AR, R, ERR; one burst outstanding at a time.
REQ-013 cmd_ready SHALL be 1 only in IDLE; command accepted on cmd_valid&&cmd_ready and latched.
REQ-014 Illegal command (cmd_burst==2'b11; WRAP with cmd_len not in {1,3,7,15}; cmd_size>log2(DATA_WIDTH/8); FIXED with cmd_len>15) SHALL go IDLE->ERR, issue no bus traffic, then pulse done with done_resp=2'b10 and return to IDLE.
REQ-015 Legal write SHALL go IDLE->AW; legal read IDLE->AR.
REQ-016 In AW/AR, AxVALID SHALL be 1 with AxADDR/AxLEN/AxSIZE/AxBURST from the latched command, held stable until AxREADY; on handshake AW->W, AR->R.
REQ-017 W channel SHALL use a one-entry output register: wr_ready = (state==W) && beats_loaded<=len && (!WVALID || WREADY); no combinational path from any AXI input to any AXI output.
REQ-018 WVALID SHALL be held with WDATA stable until WREADY; WLAST SHALL be 1 exactly on beat index len (8-bit beat counter, 0-based).
REQ-019 After the WLAST handshake, state SHALL go W->B; BREADY SHALL be 1 only in B.
REQ-020 On BVALID&&BREADY SHALL pulse done next cycle with done_resp=BRESP and return to IDLE.
REQ-021 In R, RREADY SHALL be 1; each RVALID&&RREADY SHALL register RDATA, RRESP, RLAST onto rd_data, rd_resp, rd_last with rd_valid pulsed one cycle later.
REQ-022 Read done_resp SHALL be the numerically highest RRESP seen in the burst.
REQ-023 Read burst SHALL end on the beat counter reaching len; if RLAST disagrees with the counter (early or missing), done_resp SHALL be 2'b10.
REQ-024 done SHALL pulse exactly one cycle per accepted command and coincide with the cycle state returns to IDLE.
REQ-025 wr_data presented outside W SHALL be ignored (wr_ready=0).

Reset
REQ-026 While ARESET=1 on a clock edge: state=IDLE; AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, rd_valid, rd_last, done=0; cmd_ready=0; AxADDR/AxLEN/WDATA/rd_data/rd_resp/done_resp=0; beat counter=0.
REQ-027 cmd_ready SHALL rise the first cycle after ARESET deasserts.
REQ-028 Reset mid-burst SHALL abort immediately: no done pulse, all VALIDs low next cycle, in-flight command discarded.

Verification
REQ-029 INCR write addr=0x0040, len=3, size=2, subordinate ready always -> AWVALID 1 cycle, 4 W beats with WLAST on 4th only, done with done_resp=0 one cycle after B handshake.
REQ-030 WRAP read addr=0x0018, len=3, size=2, RRESP=0 on beats 0,1,3 and 2'b10 on beat 2 -> 4 rd_valid pulses, rd_last on 4th, done_resp=2'b10.
REQ-031 Subordinate holds AWREADY=0 for 5 cycles and WREADY toggles each cycle -> AWADDR and WDATA stable while VALID=1 and un-accepted; no beat lost or duplicated.
REQ-032 Command cmd_burst=2'b10, cmd_len=5 -> no AWVALID/ARVALID ever asserted, done with done_resp=2'b10 within 2 cycles.
REQ-033 Read len=7 with RLAST asserted on beat 3 -> done_resp=2'b10.
REQ-034 ARESET asserted during W beat 2 of len=7 write -> all VALIDs 0 next cycle, no done, cmd_ready=1 one cycle after release.
